decode_queue_stage: RTL and testbench

//  Parametrised D-stage for the P7 MIPS pipeline. It buffers fetched instructions in a DEPTH-entry FIFO and decodes the head entry.
//  Per head instruction it produces register fields, write-back target A3, RFWR, instruction class, reserved-instruction (RI) exception and the branch-delay-slot flag.

---
 rtl/decode_queue_stage_pkg.sv | 89 ++++++++
 rtl/decode_queue_stage_if.sv | 42 ++++
 rtl/decode_queue_stage_decode.sv | 151 +++++++++++++++
 rtl/decode_queue_stage.sv | 89 ++++++++
 tb/tb_decode_queue_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_queue_stage_pkg.sv
// Shared opcode/funct constants, instruction classes and exception codes for the
// D-stage decode queue.
package decode_queue_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_ERET  = 6'h18;

  localparam logic [4:0] RS_MF = 5'h00;
  localparam logic [4:0] RS_MT = 5'h04;
  localparam logic [4:0] RS_CO = 5'h10;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_RI   = 5'd10;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_ALU_R  = 4'd1,
    CLS_ALU_I  = 4'd2,
    CLS_SHIFT  = 4'd3,
    CLS_LOAD   = 4'd4,
    CLS_STORE  = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_JUMP   = 4'd7,
    CLS_MDU    = 4'd8,
    CLS_MFMT   = 4'd9,
    CLS_COP0   = 4'd10
  } cls_e;

  typedef enum logic [1:0] {A3_NONE, A3_RD, A3_RT, A3_RA} a3_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
  } entry_t;

endpackage

// File: rtl/decode_queue_stage_if.sv
// F-to-E stream through the decode queue: push side, pop side and decoded head fields.
interface decode_queue_stage_if #(
  parameter int DEPTH = 4
);
  import decode_queue_stage_pkg::*;

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [31:0]              in_pc;
  logic [4:0]               in_exc;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [31:0]              out_pc;
  logic [4:0]               rs;
  logic [4:0]               rt;
  logic [4:0]               rd;
  logic [4:0]               shamt;
  logic [15:0]              imm16;
  logic [25:0]              imm26;
  logic [4:0]               a3;
  logic                     rfwr;
  cls_e                     cls;
  logic                     bd;
  logic [4:0]               exc_code;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_exc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, rs, rt, rd, shamt,
           imm16, imm26, a3, rfwr, cls, bd, exc_code, count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, in_exc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, rs, rt, rd, shamt,
           imm16, imm26, a3, rfwr, cls, bd, exc_code, count
  );

endinterface

// File: rtl/decode_queue_stage_decode.sv
// Combinational decoder: fields, class, write-back target and final ExcCode
// for one instruction word; masked groups decode as reserved instructions.
module decode_queue_stage_decode
  import decode_queue_stage_pkg::*;
#(
  parameter bit ENABLE_MDU  = 1'b1,
  parameter bit ENABLE_COP0 = 1'b1
) (
  input  logic [31:0] instr,
  input  logic [4:0]  exc_in,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [4:0]  a3,
  output logic        rfwr,
  output cls_e        cls,
  output logic [4:0]  exc_code
);

  logic [5:0] op;
  logic [5:0] funct;
  cls_e       cls_raw;
  a3_sel_e    sel_raw;
  a3_sel_e    sel;
  logic       ri;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign imm16 = instr[15:0];
  assign imm26 = instr[25:0];

  always_comb begin
    cls_raw = CLS_NOP;
    sel_raw = A3_NONE;
    ri      = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            cls_raw = CLS_SHIFT;
            sel_raw = A3_RD;
          end
          FN_JR:   cls_raw = CLS_JUMP;
          FN_JALR: begin
            cls_raw = CLS_JUMP;
            sel_raw = A3_RD;
          end
          FN_MFHI, FN_MFLO: begin
            if (ENABLE_MDU) begin
              cls_raw = CLS_MFMT;
              sel_raw = A3_RD;
            end else begin
              ri = 1'b1;
            end
          end
          FN_MTHI, FN_MTLO: begin
            if (ENABLE_MDU) cls_raw = CLS_MFMT;
            else            ri = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            if (ENABLE_MDU) cls_raw = CLS_MDU;
            else            ri = 1'b1;
          end
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            cls_raw = CLS_ALU_R;
            sel_raw = A3_RD;
          end
          default: ri = 1'b1;
        endcase
      end
      // Only bltz (rt=0) and bgez (rt=1) are implemented under REGIMM
      OP_REGIMM: begin
        if (rt == 5'd0 || rt == 5'd1) cls_raw = CLS_BRANCH;
        else                          ri = 1'b1;
      end
      OP_J:   cls_raw = CLS_JUMP;
      OP_JAL: begin
        cls_raw = CLS_JUMP;
        sel_raw = A3_RA;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_raw = CLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls_raw = CLS_ALU_I;
        sel_raw = A3_RT;
      end
      OP_COP0: begin
        if (!ENABLE_COP0) begin
          ri = 1'b1;
        end else begin
          case (rs)
            RS_MF: begin
              cls_raw = CLS_COP0;
              sel_raw = A3_RT;
            end
            RS_MT: cls_raw = CLS_COP0;
            RS_CO: begin
              if (funct == FN_ERET) cls_raw = CLS_COP0;
              else                  ri = 1'b1;
            end
            default: ri = 1'b1;
          endcase
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cls_raw = CLS_LOAD;
        sel_raw = A3_RT;
      end
      OP_SB, OP_SH, OP_SW: cls_raw = CLS_STORE;
      default: ri = 1'b1;
    endcase
  end

  // An all-zero word is the canonical nop, not a shift writing $0
  always_comb begin
    cls = cls_raw;
    sel = sel_raw;
    if (ri || instr == '0) begin
      cls = CLS_NOP;
      sel = A3_NONE;
    end
  end

  always_comb begin
    exc_code = EXC_NONE;
    if (exc_in != EXC_NONE) exc_code = exc_in;
    else if (ri)            exc_code = EXC_RI;
  end

  always_comb begin
    rfwr = (sel != A3_NONE) && (exc_code == EXC_NONE);
    a3   = '0;
    if (rfwr) begin
      case (sel)
        A3_RD:   a3 = rd;
        A3_RT:   a3 = rt;
        A3_RA:   a3 = 5'd31;
        default: a3 = '0;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue_stage.sv
// D-stage: DEPTH-entry instruction FIFO between F and E with combinational
// decode of the head entry and branch-delay-slot tracking.
module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter bit ENABLE_MDU  = 1'b1,
  parameter bit ENABLE_COP0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_queue_stage_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count_q;
  logic           bd_q;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  entry_t         head;
  cls_e           head_cls;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      bd_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        bd_q   <= (head_cls == CLS_BRANCH) || (head_cls == CLS_JUMP);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !bus.flush)
      mem[wr_ptr] <= '{instr: bus.in_instr, pc: bus.in_pc, exc: bus.in_exc};
  end

  // Empty queue presents an all-zero entry so decode outputs sit at reset values
  assign head = empty ? '0 : mem[rd_ptr];

  decode_queue_stage_decode #(
    .ENABLE_MDU  (ENABLE_MDU),
    .ENABLE_COP0 (ENABLE_COP0)
  ) u_decode (
    .instr    (head.instr),
    .exc_in   (head.exc),
    .rs       (bus.rs),
    .rt       (bus.rt),
    .rd       (bus.rd),
    .shamt    (bus.shamt),
    .imm16    (bus.imm16),
    .imm26    (bus.imm26),
    .a3       (bus.a3),
    .rfwr     (bus.rfwr),
    .cls      (head_cls),
    .exc_code (bus.exc_code)
  );

  assign bus.cls       = head_cls;
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.bd        = bd_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: a full-featured instance and an
// instance with MDU and COP0 masked, fed identical stimulus.
module tb_decode_queue_stage;
  import decode_queue_stage_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  decode_queue_stage_if #(.DEPTH(4)) bus ();
  decode_queue_stage_if #(.DEPTH(4)) bus_min ();

  decode_queue_stage #(.DEPTH(4), .ENABLE_MDU(1'b1), .ENABLE_COP0(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  decode_queue_stage #(.DEPTH(4), .ENABLE_MDU(1'b0), .ENABLE_COP0(1'b0)) dut_min (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_min)
  );

  assign bus_min.flush     = bus.flush;
  assign bus_min.in_valid  = bus.in_valid;
  assign bus_min.in_instr  = bus.in_instr;
  assign bus_min.in_pc     = bus.in_pc;
  assign bus_min.in_exc    = bus.in_exc;
  assign bus_min.out_ready = bus.out_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] exc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_exc   = exc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.rfwr !== 1'b0 || bus.a3 !== 5'd0 || bus.exc_code !== 5'd0 || bus.cls !== CLS_NOP || bus.bd !== 1'b0)
      begin fails++; $display("FAIL reset_decode: got rfwr=%b a3=%0d exc=%0d cls=%0d bd=%b want 0 0 0 0 0",
                              bus.rfwr, bus.a3, bus.exc_code, bus.cls, bus.bd); end
  endtask

  task automatic test_addu();
    push_one(32'h0022_1821, 32'h0000_0100, 5'd0);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL addu_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.a3 !== 5'd3 || bus.rfwr !== 1'b1) begin fails++; $display("FAIL addu_a3: got a3=%0d rfwr=%b want 3 1", bus.a3, bus.rfwr); end
    checks++; if (bus.cls !== CLS_ALU_R || bus.bd !== 1'b0 || bus.exc_code !== 5'd0)
      begin fails++; $display("FAIL addu_cls: got cls=%0d bd=%b exc=%0d want 1 0 0", bus.cls, bus.bd, bus.exc_code); end
    checks++; if (bus.rs !== 5'd1 || bus.rt !== 5'd2 || bus.rd !== 5'd3 || bus.out_pc !== 32'h100)
      begin fails++; $display("FAIL addu_fields: got rs=%0d rt=%0d rd=%0d pc=%h want 1 2 3 100", bus.rs, bus.rt, bus.rd, bus.out_pc); end
    pop_one();
    checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0)
      begin fails++; $display("FAIL addu_drain: got count=%0d valid=%b want 0 0", bus.count, bus.out_valid); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    for (int k = 1; k <= 4; k++) push_one(32'h2400_0000 | (k << 16) | k, 32'h200 + 4 * k, 5'd0);
    checks++; if (bus.in_ready !== 1'b0 || bus.count !== 3'd4)
      begin fails++; $display("FAIL full_state: got in_ready=%b count=%0d want 0 4", bus.in_ready, bus.count); end
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h2405_0005;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_no_bypass: got in_ready=%b want 0", bus.in_ready); end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd3) begin fails++; $display("FAIL full_pop_offer: got count=%0d want 3", bus.count); end
    for (int k = 2; k <= 4; k++) begin
      w = 32'h2400_0000 | (k << 16) | k;
      checks++; if (bus.out_instr !== w || bus.a3 !== 5'(k) || bus.cls !== CLS_ALU_I)
        begin fails++; $display("FAIL full_order_%0d: got instr=%h a3=%0d cls=%0d want %h %0d 2", k, bus.out_instr, bus.a3, bus.cls, w, k); end
      pop_one();
    end
    checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0)
      begin fails++; $display("FAIL full_drain: got count=%0d valid=%b want 0 0", bus.count, bus.out_valid); end
  endtask

  task automatic test_bd();
    push_one(32'h1022_0003, 32'h300, 5'd0);
    push_one(32'h3423_0005, 32'h304, 5'd0);
    push_one(32'h0022_1821, 32'h308, 5'd0);
    checks++; if (bus.cls !== CLS_BRANCH || bus.rfwr !== 1'b0 || bus.bd !== 1'b0)
      begin fails++; $display("FAIL bd_beq: got cls=%0d rfwr=%b bd=%b want 6 0 0", bus.cls, bus.rfwr, bus.bd); end
    pop_one();
    checks++; if (bus.bd !== 1'b1 || bus.a3 !== 5'd3 || bus.cls !== CLS_ALU_I)
      begin fails++; $display("FAIL bd_ori: got bd=%b a3=%0d cls=%0d want 1 3 2", bus.bd, bus.a3, bus.cls); end
    pop_one();
    checks++; if (bus.bd !== 1'b0 || bus.out_instr !== 32'h0022_1821)
      begin fails++; $display("FAIL bd_after: got bd=%b instr=%h want 0 00221821", bus.bd, bus.out_instr); end
    pop_one();
    push_one(32'h0C00_0010, 32'h400, 5'd0);
    checks++; if (bus.a3 !== 5'd31 || bus.rfwr !== 1'b1 || bus.cls !== CLS_JUMP)
      begin fails++; $display("FAIL jal_decode: got a3=%0d rfwr=%b cls=%0d want 31 1 7", bus.a3, bus.rfwr, bus.cls); end
    pop_one();
    checks++; if (bus.out_valid !== 1'b0 || bus.bd !== 1'b1)
      begin fails++; $display("FAIL bd_empty: got valid=%b bd=%b want 0 1", bus.out_valid, bus.bd); end
    push_one(32'h0000_0000, 32'h404, 5'd0);
    checks++; if (bus.bd !== 1'b1 || bus.cls !== CLS_NOP || bus.rfwr !== 1'b0 || bus.a3 !== 5'd0)
      begin fails++; $display("FAIL nop_slot: got bd=%b cls=%0d rfwr=%b a3=%0d want 1 0 0 0", bus.bd, bus.cls, bus.rfwr, bus.a3); end
    pop_one();
    checks++; if (bus.bd !== 1'b0) begin fails++; $display("FAIL bd_clear: got %b want 0", bus.bd); end
  endtask

  task automatic test_ri();
    push_one(32'hFC00_0000, 32'h500, 5'd0);
    push_one(32'hFC00_0000, 32'h504, EXC_ADEL);
    push_one(32'h0022_1821, 32'h508, EXC_ADEL);
    checks++; if (bus.exc_code !== 5'd10 || bus.rfwr !== 1'b0 || bus.a3 !== 5'd0 || bus.cls !== CLS_NOP)
      begin fails++; $display("FAIL ri_decode: got exc=%0d rfwr=%b a3=%0d cls=%0d want 10 0 0 0", bus.exc_code, bus.rfwr, bus.a3, bus.cls); end
    pop_one();
    checks++; if (bus.exc_code !== 5'd4) begin fails++; $display("FAIL adel_over_ri: got %0d want 4", bus.exc_code); end
    pop_one();
    checks++; if (bus.exc_code !== 5'd4 || bus.rfwr !== 1'b0 || bus.a3 !== 5'd0)
      begin fails++; $display("FAIL adel_kills_wr: got exc=%0d rfwr=%b a3=%0d want 4 0 0", bus.exc_code, bus.rfwr, bus.a3); end
    pop_one();
  endtask

  task automatic test_flush();
    push_one(32'h1022_0003, 32'h600, 5'd0);
    pop_one();
    for (int k = 0; k < 3; k++) push_one(32'h3423_0005, 32'h604 + 4 * k, 5'd0);
    checks++; if (bus.count !== 3'd3 || bus.bd !== 1'b1)
      begin fails++; $display("FAIL flush_pre: got count=%0d bd=%b want 3 1", bus.count, bus.bd); end
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.bd !== 1'b0)
      begin fails++; $display("FAIL flush_post: got count=%0d valid=%b bd=%b want 0 0 0", bus.count, bus.out_valid, bus.bd); end
  endtask

  task automatic test_cop0_mdu();
    push_one(32'h4008_6000, 32'h700, 5'd0);
    checks++; if (bus_min.exc_code !== 5'd10 || bus_min.rfwr !== 1'b0)
      begin fails++; $display("FAIL mfc0_masked: got exc=%0d rfwr=%b want 10 0", bus_min.exc_code, bus_min.rfwr); end
    checks++; if (bus.a3 !== 5'd8 || bus.rfwr !== 1'b1 || bus.cls !== CLS_COP0 || bus.exc_code !== 5'd0)
      begin fails++; $display("FAIL mfc0_enabled: got a3=%0d rfwr=%b cls=%0d exc=%0d want 8 1 10 0", bus.a3, bus.rfwr, bus.cls, bus.exc_code); end
    pop_one();
    push_one(32'h0022_0018, 32'h704, 5'd0);
    checks++; if (bus_min.exc_code !== 5'd10 || bus_min.cls !== CLS_NOP)
      begin fails++; $display("FAIL mult_masked: got exc=%0d cls=%0d want 10 0", bus_min.exc_code, bus_min.cls); end
    checks++; if (bus.cls !== CLS_MDU || bus.rfwr !== 1'b0 || bus.exc_code !== 5'd0)
      begin fails++; $display("FAIL mult_enabled: got cls=%0d rfwr=%b exc=%0d want 8 0 0", bus.cls, bus.rfwr, bus.exc_code); end
    pop_one();
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.in_exc    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_addu();
    test_full();
    test_bd();
    test_ri();
    test_flush();
    test_cop0_mdu();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
